// File: rtl/attack_resolver_pkg.sv
// Shared types and codes for the tic-tac-toe attack resolver: cell/winner codes,
// FSM state encoding and the board shape.
package game_pkg;
  localparam int BOARD_N = 3;
  localparam logic [3:0] MAX_MOVES = 4'(BOARD_N * BOARD_N);

  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] P1    = 2'b01;
  localparam logic [1:0] P2    = 2'b10;

  localparam logic [1:0] W_NONE = 2'b00;
  localparam logic [1:0] W_P1   = 2'b01;
  localparam logic [1:0] W_P2   = 2'b10;
  localparam logic [1:0] W_DRAW = 2'b11;

  typedef enum logic [2:0] {WAIT, WRITE, EVAL, SWAP, OVER} state_t;

  typedef logic [BOARD_N:1][BOARD_N:1][1:0] board_t;

  function automatic logic [1:0] other_player(input logic [1:0] p);
    return (p == P1) ? P2 : P1;
  endfunction
endpackage

// File: rtl/attack_resolver_if.sv
// Attack handshake between the movement block (master) and the resolver (slave):
// commit strobes with target cell, grants, refusal and turn-expiry pulses.
interface attack_resolver_if;
  logic       end_attack_p1;
  logic       end_attack_p2;
  logic [1:0] row;
  logic [1:0] col;
  logic       en_attack_p1;
  logic       en_attack_p2;
  logic       reject;
  logic       timeout;

  modport master (
    output end_attack_p1, end_attack_p2, row, col,
    input  en_attack_p1, en_attack_p2, reject, timeout
  );

  modport slave (
    input  end_attack_p1, end_attack_p2, row, col,
    output en_attack_p1, en_attack_p2, reject, timeout
  );
endinterface

// File: rtl/attack_resolver_win_checker.sv
// Combinational three-in-a-row test of one player over all rows, columns and
// both diagonals.
module win_checker
  import game_pkg::*;
(
  input  board_t     board,
  input  logic [1:0] player,
  output logic       win
);
  always_comb begin
    logic diag_q, diag_a;
    win    = 1'b0;
    diag_q = 1'b1;
    diag_a = 1'b1;
    for (int i = 1; i <= BOARD_N; i++) begin
      logic row_all, col_all;
      row_all = 1'b1;
      col_all = 1'b1;
      for (int j = 1; j <= BOARD_N; j++) begin
        row_all = row_all & (board[2'(i)][2'(j)] == player);
        col_all = col_all & (board[2'(j)][2'(i)] == player);
      end
      win    = win | row_all | col_all;
      diag_q = diag_q & (board[2'(i)][2'(i)] == player);
      diag_a = diag_a & (board[2'(i)][2'(BOARD_N + 1 - i)] == player);
    end
    win = win | diag_q | diag_a;
  end
endmodule

// File: rtl/attack_resolver.sv
// Turn arbitration and board update for two-player tic-tac-toe.
// Define TURN_TIMER_EN to add the per-turn expiry counter driving timeout.
module attack_resolver
  import game_pkg::*;
#(
  parameter int unsigned TURN_CYCLES = 750_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                new_game,
  attack_resolver_if.slave    atk,
  output board_t              board,
  output logic [1:0]          current_player,
  output logic [1:0]          winner,
  output logic                game_over,
  output logic [3:0]          move_count
);
  state_t     state_q, state_d;
  logic [1:0] player_q, player_d;
  board_t     board_q, board_d;
  logic [3:0] mc_q, mc_d;
  logic [1:0] winner_q, winner_d;
  logic [1:0] lrow_q, lrow_d, lcol_q, lcol_d, lplayer_q, lplayer_d;
  logic       reject_q, reject_d;
  logic       accept, cell_ok, win;

  // Only the strobe of the player to move counts, so a simultaneous pair resolves itself.
  assign accept  = (player_q == P1) ? atk.end_attack_p1 : atk.end_attack_p2;
  // Row/col are 2 bits, so 0 is the only out-of-range coordinate.
  assign cell_ok = (lrow_q != 2'd0) && (lcol_q != 2'd0) &&
                   (board_q[lrow_q][lcol_q] == EMPTY);

  win_checker u_win (
    .board  (board_q),
    .player (lplayer_q),
    .win    (win)
  );

  always_comb begin
    state_d   = state_q;
    player_d  = player_q;
    board_d   = board_q;
    mc_d      = mc_q;
    winner_d  = winner_q;
    lrow_d    = lrow_q;
    lcol_d    = lcol_q;
    lplayer_d = lplayer_q;
    reject_d  = 1'b0;
    if (new_game) begin
      state_d  = WAIT;
      player_d = P1;
      board_d  = '0;
      mc_d     = '0;
      winner_d = W_NONE;
    end else begin
      unique case (state_q)
        WAIT: if (accept) begin
          lrow_d    = atk.row;
          lcol_d    = atk.col;
          lplayer_d = player_q;
          state_d   = WRITE;
        end
        WRITE: if (cell_ok) begin
          board_d[lrow_q][lcol_q] = lplayer_q;
          if (mc_q < MAX_MOVES) mc_d = mc_q + 4'd1;
          state_d = EVAL;
        end else begin
          reject_d = 1'b1;
          state_d  = WAIT;
        end
        EVAL: if (win) begin
          winner_d = lplayer_q;
          state_d  = OVER;
        end else if (mc_q == MAX_MOVES) begin
          winner_d = W_DRAW;
          state_d  = OVER;
        end else begin
          state_d = SWAP;
        end
        SWAP: begin
          player_d = other_player(player_q);
          state_d  = WAIT;
        end
        OVER: ;
        default: state_d = WAIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= WAIT;
      player_q  <= P1;
      board_q   <= '0;
      mc_q      <= '0;
      winner_q  <= W_NONE;
      lrow_q    <= '0;
      lcol_q    <= '0;
      lplayer_q <= P1;
      reject_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      player_q  <= player_d;
      board_q   <= board_d;
      mc_q      <= mc_d;
      winner_q  <= winner_d;
      lrow_q    <= lrow_d;
      lcol_q    <= lcol_d;
      lplayer_q <= lplayer_d;
      reject_q  <= reject_d;
    end
  end

`ifdef TURN_TIMER_EN
  localparam logic [31:0] TMAX = 32'(TURN_CYCLES - 1);
  logic [31:0] timer_q, timer_d;
  logic        timeout_q, timeout_d;

  // Counts only while waiting for a move; any exit from WAIT leaves it at 0, OVER holds it.
  always_comb begin
    timer_d   = timer_q;
    timeout_d = 1'b0;
    if (new_game) begin
      timer_d = '0;
    end else begin
      unique case (state_q)
        WAIT: if (accept) begin
          timer_d = '0;
        end else if (timer_q == TMAX) begin
          timer_d   = '0;
          timeout_d = 1'b1;
        end else begin
          timer_d = timer_q + 32'd1;
        end
        OVER:    ;
        default: timer_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
    end
  end

  assign atk.timeout = timeout_q;
`else
  // Parameter kept so both builds share one instantiation signature.
  logic unused_turn_cycles;
  assign unused_turn_cycles = ^32'(TURN_CYCLES);
  assign atk.timeout        = 1'b0;
`endif

  assign board          = board_q;
  assign current_player = player_q;
  assign winner         = winner_q;
  assign move_count     = mc_q;
  assign game_over      = (state_q == OVER);
  assign atk.reject     = reject_q;
  assign atk.en_attack_p1 = (state_q == WAIT) && (player_q == P1);
  assign atk.en_attack_p2 = (state_q == WAIT) && (player_q == P2);
endmodule

// File: tb/tb_attack_resolver.sv
// Bench for attack_resolver: directed scenarios plus random games checked
// against a cell-array game model.
module tb_attack_resolver;
  import game_pkg::*;

  localparam int unsigned TC = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       new_game = 1'b0;
  board_t     board;
  logic [1:0] current_player, winner;
  logic       game_over;
  logic [3:0] move_count;

  attack_resolver_if atk();

  int errors = 0;
  int checks = 0;

  int m_b [1:3][1:3];
  int m_cur, m_mc, m_win;
  bit m_over;

  attack_resolver #(.TURN_CYCLES(TC)) dut (
    .clk(clk), .rst(rst), .new_game(new_game), .atk(atk),
    .board(board), .current_player(current_player), .winner(winner),
    .game_over(game_over), .move_count(move_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  function automatic void model_clear();
    for (int r = 1; r <= 3; r++)
      for (int c = 1; c <= 3; c++) m_b[r][c] = 0;
    m_cur = 1; m_mc = 0; m_win = 0; m_over = 0;
  endfunction

  function automatic board_t exp_board();
    board_t v;
    v = '0;
    for (int r = 1; r <= 3; r++)
      for (int c = 1; c <= 3; c++) v[2'(r)][2'(c)] = 2'(m_b[r][c]);
    return v;
  endfunction

  function automatic bit model_win(input int p);
    int d0, d1, rc, cc;
    d0 = 0; d1 = 0;
    for (int i = 1; i <= 3; i++) begin
      rc = 0; cc = 0;
      for (int j = 1; j <= 3; j++) begin
        if (m_b[i][j] == p) rc++;
        if (m_b[j][i] == p) cc++;
      end
      if (rc == 3 || cc == 3) return 1'b1;
      if (m_b[i][i] == p) d0++;
      if (m_b[i][4-i] == p) d1++;
    end
    return (d0 == 3) || (d1 == 3);
  endfunction

  // One strobe from player p (or both players) at (r,c), checked stage by stage.
  task automatic attempt(input int p, input int r, input int c, input bit both);
    bit acc, legal;
    int ap;
    board_t eb;
    logic e1, e2;
    acc   = !m_over && (both || p == m_cur);
    ap    = m_cur;
    legal = 1'b0;
    if (acc && r >= 1 && c >= 1) legal = (m_b[r][c] == 0);
    @(negedge clk);
    atk.end_attack_p1 = both || (p == 1);
    atk.end_attack_p2 = both || (p == 2);
    atk.row = 2'(r);
    atk.col = 2'(c);
    @(negedge clk);
    atk.end_attack_p1 = 1'b0;
    atk.end_attack_p2 = 1'b0;
    e1 = !acc && !m_over && m_cur == 1;
    e2 = !acc && !m_over && m_cur == 2;
    checks++; if (atk.en_attack_p1 !== e1) begin errors++; $display("FAIL grant_p1_n: got %b exp %b", atk.en_attack_p1, e1); end
    checks++; if (atk.en_attack_p2 !== e2) begin errors++; $display("FAIL grant_p2_n: got %b exp %b", atk.en_attack_p2, e2); end
    if (legal) begin
      m_b[r][c] = ap;
      m_mc++;
      if (model_win(ap)) begin m_win = ap; m_over = 1'b1; end
      else if (m_mc == 9) begin m_win = 3; m_over = 1'b1; end
    end
    eb = exp_board();
    @(negedge clk);
    checks++; if (board !== eb) begin errors++; $display("FAIL board: got %h exp %h (p%0d r%0d c%0d)", board, eb, p, r, c); end
    checks++; if (move_count !== 4'(m_mc)) begin errors++; $display("FAIL move_count: got %0d exp %0d", move_count, m_mc); end
    checks++; if (atk.reject !== (acc && !legal)) begin errors++; $display("FAIL reject: got %b exp %b", atk.reject, acc && !legal); end
    @(negedge clk);
    checks++; if (winner !== 2'(m_win)) begin errors++; $display("FAIL winner: got %0d exp %0d", winner, m_win); end
    checks++; if (game_over !== m_over) begin errors++; $display("FAIL game_over: got %b exp %b", game_over, m_over); end
    checks++; if (atk.reject !== 1'b0) begin errors++; $display("FAIL reject_width: got %b exp 0", atk.reject); end
    e1 = !legal && !m_over && m_cur == 1;
    e2 = !legal && !m_over && m_cur == 2;
    checks++; if (atk.en_attack_p1 !== e1) begin errors++; $display("FAIL grant_p1_n2: got %b exp %b", atk.en_attack_p1, e1); end
    checks++; if (atk.en_attack_p2 !== e2) begin errors++; $display("FAIL grant_p2_n2: got %b exp %b", atk.en_attack_p2, e2); end
    if (legal && !m_over) m_cur = 3 - m_cur;
    @(negedge clk);
    checks++; if (current_player !== 2'(m_cur)) begin errors++; $display("FAIL current_player: got %0d exp %0d", current_player, m_cur); end
    checks++; if (atk.en_attack_p1 !== (!m_over && m_cur == 1)) begin errors++; $display("FAIL grant_p1: got %b", atk.en_attack_p1); end
    checks++; if (atk.en_attack_p2 !== (!m_over && m_cur == 2)) begin errors++; $display("FAIL grant_p2: got %b", atk.en_attack_p2); end
  endtask

  task automatic do_new_game();
    @(negedge clk); new_game = 1'b1;
    @(negedge clk); new_game = 1'b0;
    model_clear();
    checks++; if (board !== '0) begin errors++; $display("FAIL ng_board: got %h exp 0", board); end
    checks++; if (current_player !== P1) begin errors++; $display("FAIL ng_player: got %0d exp 1", current_player); end
    checks++; if (move_count !== 4'd0) begin errors++; $display("FAIL ng_count: got %0d exp 0", move_count); end
    checks++; if (winner !== W_NONE || game_over !== 1'b0) begin errors++; $display("FAIL ng_winner: got %0d/%b exp 0/0", winner, game_over); end
    checks++; if (atk.en_attack_p1 !== 1'b1) begin errors++; $display("FAIL ng_grant: got %b exp 1", atk.en_attack_p1); end
  endtask

  task automatic test_reset();
    atk.end_attack_p1 = 1'b0; atk.end_attack_p2 = 1'b0; atk.row = 2'd0; atk.col = 2'd0;
    #2 rst = 1'b0;
    #3;
    checks++; if (board !== '0) begin errors++; $display("FAIL rst_board: got %h exp 0", board); end
    checks++; if (current_player !== P1) begin errors++; $display("FAIL rst_player: got %0d exp 1", current_player); end
    checks++; if (atk.en_attack_p1 !== 1'b1 || atk.en_attack_p2 !== 1'b0) begin errors++; $display("FAIL rst_grant: got %b%b exp 10", atk.en_attack_p1, atk.en_attack_p2); end
    checks++; if (winner !== W_NONE || move_count !== 4'd0) begin errors++; $display("FAIL rst_win_cnt: got %0d/%0d exp 0/0", winner, move_count); end
    checks++; if (atk.reject !== 1'b0 || atk.timeout !== 1'b0 || game_over !== 1'b0) begin errors++; $display("FAIL rst_pulses: got %b%b%b exp 000", atk.reject, atk.timeout, game_over); end
    @(negedge clk); rst = 1'b1;
    model_clear();
  endtask

  task automatic test_first_move();
    attempt(1, 1, 1, 1'b0);
    checks++; if (board[1][1] !== P1) begin errors++; $display("FAIL first_cell: got %0d exp 1", board[1][1]); end
  endtask

  task automatic test_reject();
    attempt(2, 1, 1, 1'b0);   // occupied cell
    attempt(1, 2, 2, 1'b0);   // out of turn, ignored
    attempt(2, 0, 2, 1'b0);   // row out of range
    attempt(2, 3, 0, 1'b0);   // col out of range
    attempt(2, 3, 3, 1'b0);
  endtask

  task automatic test_p1_win();
    do_new_game();
    attempt(1, 1, 1, 1'b0); attempt(2, 1, 2, 1'b0);
    attempt(1, 2, 2, 1'b0); attempt(2, 1, 3, 1'b0);
    attempt(1, 3, 3, 1'b0);
    checks++; if (winner !== W_P1 || game_over !== 1'b1) begin errors++; $display("FAIL p1_win: got %0d/%b exp 1/1", winner, game_over); end
    attempt(2, 3, 1, 1'b0);
    attempt(1, 3, 2, 1'b0);
    attempt(1, 2, 1, 1'b1);
  endtask

  task automatic test_draw();
    do_new_game();
    attempt(1, 1, 1, 1'b0); attempt(2, 1, 2, 1'b0); attempt(1, 1, 3, 1'b0);
    attempt(2, 2, 2, 1'b0); attempt(1, 2, 1, 1'b0); attempt(2, 2, 3, 1'b0);
    attempt(1, 3, 2, 1'b0); attempt(2, 3, 1, 1'b0); attempt(1, 3, 3, 1'b0);
    checks++; if (winner !== W_DRAW || move_count !== 4'd9) begin errors++; $display("FAIL draw: got %0d/%0d exp 3/9", winner, move_count); end
    attempt(1, 2, 2, 1'b1);
    checks++; if (move_count !== 4'd9) begin errors++; $display("FAIL count_sat: got %0d exp 9", move_count); end
  endtask

  task automatic test_both_strobes();
    do_new_game();
    attempt(1, 2, 2, 1'b1);
    attempt(2, 1, 1, 1'b1);
    attempt(1, 3, 1, 1'b1);
  endtask

  task automatic test_newgame_priority();
    do_new_game();
    attempt(1, 2, 2, 1'b0); attempt(2, 1, 3, 1'b0);
    @(negedge clk);
    new_game = 1'b1; atk.end_attack_p1 = 1'b1; atk.row = 2'd3; atk.col = 2'd3;
    @(negedge clk);
    new_game = 1'b0; atk.end_attack_p1 = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    checks++; if (board !== '0) begin errors++; $display("FAIL ngp_board: got %h exp 0", board); end
    checks++; if (move_count !== 4'd0 || current_player !== P1) begin errors++; $display("FAIL ngp_state: got %0d/%0d exp 0/1", move_count, current_player); end
    checks++; if (atk.en_attack_p1 !== 1'b1) begin errors++; $display("FAIL ngp_grant: got %b exp 1", atk.en_attack_p1); end
  endtask

  task automatic test_reset_mid();
    do_new_game();
    attempt(1, 1, 1, 1'b0);
    @(negedge clk); atk.end_attack_p2 = 1'b1; atk.row = 2'd2; atk.col = 2'd2;
    @(negedge clk); atk.end_attack_p2 = 1'b0;
    @(negedge clk);   // resolver now evaluating
    rst = 1'b0;
    #1;
    checks++; if (board !== '0) begin errors++; $display("FAIL rmid_board: got %h exp 0", board); end
    checks++; if (current_player !== P1 || move_count !== 4'd0) begin errors++; $display("FAIL rmid_state: got %0d/%0d exp 1/0", current_player, move_count); end
    checks++; if (atk.en_attack_p1 !== 1'b1 || atk.en_attack_p2 !== 1'b0) begin errors++; $display("FAIL rmid_grant: got %b%b exp 10", atk.en_attack_p1, atk.en_attack_p2); end
    @(negedge clk); rst = 1'b1;
    model_clear();
    attempt(1, 3, 3, 1'b0);
    @(negedge clk); atk.end_attack_p2 = 1'b1; atk.row = 2'd1; atk.col = 2'd2;
    @(negedge clk); atk.end_attack_p2 = 1'b0;
    rst = 1'b0;       // abandon the attack before its write edge
    @(negedge clk); rst = 1'b1;
    model_clear();
    repeat (3) @(negedge clk);
    checks++; if (board !== '0 || move_count !== 4'd0) begin errors++; $display("FAIL rwrite_board: got %h/%0d exp 0/0", board, move_count); end
  endtask

  task automatic test_timer();
    int n, first, exp_n, exp_first;
`ifdef TURN_TIMER_EN
    exp_n = 5; exp_first = 8;
`else
    exp_n = 0; exp_first = -1;
`endif
    do_new_game();
    n = 0; first = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (atk.timeout === 1'b1) begin
        n++;
        if (first < 0) first = i;
        checks++; if (i % 8 != 0) begin errors++; $display("FAIL timeout_phase: pulse at %0d exp multiple of 8", i); end
      end
    end
    checks++; if (n !== exp_n) begin errors++; $display("FAIL timeout_count: got %0d exp %0d", n, exp_n); end
    checks++; if (first !== exp_first) begin errors++; $display("FAIL timeout_first: got %0d exp %0d", first, exp_first); end
    attempt(1, 1, 1, 1'b0); attempt(2, 2, 1, 1'b0);
    attempt(1, 1, 2, 1'b0); attempt(2, 2, 2, 1'b0);
    attempt(1, 1, 3, 1'b0);
    n = 0;
    repeat (30) begin
      @(negedge clk);
      if (atk.timeout === 1'b1) n++;
    end
    checks++; if (n !== 0) begin errors++; $display("FAIL timeout_over: got %0d pulses exp 0", n); end
  endtask

  task automatic test_random_games();
    int p, r, c;
    bit both;
    for (int g = 0; g < 6; g++) begin
      do_new_game();
      for (int k = 0; k < 40 && !m_over; k++) begin
        p    = ($urandom_range(0, 7) == 0) ? 3 - m_cur : m_cur;
        r    = $urandom_range(0, 3);
        c    = $urandom_range(0, 3);
        both = ($urandom_range(0, 9) == 0);
        attempt(p, r, c, both);
      end
      attempt($urandom_range(1, 2), $urandom_range(1, 3), $urandom_range(1, 3), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_first_move();
    test_reject();
    test_p1_win();
    test_draw();
    test_both_strobes();
    test_newgame_priority();
    test_reset_mid();
    test_timer();
    test_random_games();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
